// File: rtl/row_window_splitter.sv
// Splits one full output-width row into N_COL_FEATURE overlapping stride windows, one per
// handshake. A pending slot lets the next row load while the current one drains.
module row_window_splitter #(
    parameter int BIT_WIDTH     = 8,
    parameter int N_COL_FEATURE = 8,
    parameter int N_COL_KERNEL  = 5,
    parameter int NUM_STRIDE    = 2,
    parameter int N_PIX_IN      = N_COL_FEATURE * N_COL_KERNEL,
    parameter int N_PIX_OUT     = (N_COL_FEATURE - 1) * NUM_STRIDE + N_COL_KERNEL
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   row_valid,
    output logic                                   row_ready,
    input  logic [2*BIT_WIDTH*N_PIX_OUT-1:0]       row_data,
    output logic                                   win_valid,
    input  logic                                   win_ready,
    output logic [2*BIT_WIDTH*N_COL_KERNEL-1:0]    win_data,
    output logic [N_COL_FEATURE-1:0]               win_strobe,
    output logic [2*BIT_WIDTH*N_PIX_IN-1:0]        win_bus,
    output logic                                   win_last,
    output logic                                   busy
);

    localparam int W     = 2 * BIT_WIDTH;
    localparam int ROW_W = W * N_PIX_OUT;
    localparam int WIN_W = W * N_COL_KERNEL;
    localparam int BUS_W = W * N_PIX_IN;
    localparam int IDX_W = (N_COL_FEATURE > 1) ? $clog2(N_COL_FEATURE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COL_FEATURE - 1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t             state, state_n;
    logic [ROW_W-1:0]   active_row, active_n;
    logic [ROW_W-1:0]   pending_row, pending_n;
    logic               pending_valid, pending_valid_n;
    logic [IDX_W-1:0]   idx, idx_n;

    logic [WIN_W-1:0]          win_data_n;
    logic [N_COL_FEATURE-1:0]  win_strobe_n;
    logic [BUS_W-1:0]          win_bus_n;
    logic                      win_last_n;

    logic row_fire;
    logic win_fire;

    assign row_ready = rst_n && !pending_valid;
    assign busy      = (state == EMIT) || pending_valid;
    assign row_fire  = row_valid && row_ready;
    assign win_fire  = win_valid && win_ready;

    // NOTE: every next-state variable gets its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_n         = state;
        active_n        = active_row;
        pending_n       = pending_row;
        pending_valid_n = pending_valid;
        idx_n           = idx;
        case (state)
            IDLE: begin
                if (row_fire) begin
                    active_n = row_data;
                    idx_n    = '0;
                    state_n  = EMIT;
                end
            end
            EMIT: begin
                if (win_fire && idx == LAST_IDX) begin
                    // Pending wins over a same-cycle row; row_ready is low then anyway.
                    if (pending_valid) begin
                        active_n        = pending_row;
                        pending_valid_n = 1'b0;
                        idx_n           = '0;
                    end else if (row_fire) begin
                        active_n = row_data;
                        idx_n    = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    if (win_fire)
                        idx_n = idx + IDX_W'(1);
                    if (row_fire) begin
                        pending_n       = row_data;
                        pending_valid_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Window outputs are computed from next state so they can be registered with no extra latency.
    always_comb begin
        win_data_n   = '0;
        win_strobe_n = '0;
        win_bus_n    = '0;
        win_last_n   = 1'b0;
        if (state_n == EMIT) begin
            for (int k = 0; k < N_COL_FEATURE; k++) begin
                if (idx_n == IDX_W'(k)) begin
                    win_data_n                   = active_n[W*(N_PIX_OUT-k*NUM_STRIDE)-1 -: WIN_W];
                    win_bus_n[k*WIN_W +: WIN_W]  = active_n[W*(N_PIX_OUT-k*NUM_STRIDE)-1 -: WIN_W];
                    win_strobe_n[k]              = 1'b1;
                end
            end
            win_last_n = (idx_n == LAST_IDX);
        end
    end

    // NOTE: the row buffers are cleared on reset too, so no stale pixels survive a discarded row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            active_row    <= '0;
            pending_row   <= '0;
            pending_valid <= 1'b0;
            idx           <= '0;
            win_valid     <= 1'b0;
            win_data      <= '0;
            win_strobe    <= '0;
            win_bus       <= '0;
            win_last      <= 1'b0;
        end else begin
            state         <= state_n;
            active_row    <= active_n;
            pending_row   <= pending_n;
            pending_valid <= pending_valid_n;
            idx           <= idx_n;
            win_valid     <= (state_n == EMIT);
            win_data      <= win_data_n;
            win_strobe    <= win_strobe_n;
            win_bus       <= win_bus_n;
            win_last      <= win_last_n;
        end
    end

endmodule

// File: tb/tb_row_window_splitter.sv
// Scoreboard bench for row_window_splitter: default geometry plus K=3/S=3 and K=4/S=1 variants.
module tb_row_window_splitter;

    localparam int BW  = 8;
    localparam int W   = 2 * BW;
    localparam int F   = 8;
    localparam int K   = 5;
    localparam int S   = 2;
    localparam int NPO = (F - 1) * S + K;
    localparam int NPI = F * K;

    typedef logic [W*NPO-1:0] row_t;
    typedef logic [W*K-1:0]   win_t;
    typedef logic [W*NPI-1:0] bus_t;

    typedef struct packed {
        win_t           data;
        logic [F-1:0]   strobe;
        bus_t           bus;
        logic           last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         row_valid = 1'b0;
    logic         row_ready;
    row_t         row_data = '0;
    logic         win_valid;
    logic         win_ready = 1'b1;
    win_t         win_data;
    logic [F-1:0] win_strobe;
    bus_t         win_bus;
    logic         win_last;
    logic         busy;

    // K=3, S=3 variant: 24 pixels per row, window 48 bits, bus 384 bits
    logic          k3_valid = 1'b0;
    logic          k3_ready;
    logic [383:0]  k3_row = '0;
    logic          k3_wv;
    logic [47:0]   k3_data;
    logic [7:0]    k3_strobe;
    logic [383:0]  k3_bus;
    logic          k3_last;
    logic          k3_busy;

    // K=4, S=1 variant: 11 pixels per row, window 64 bits, bus 512 bits
    logic          k4_valid = 1'b0;
    logic          k4_ready;
    logic [175:0]  k4_row = '0;
    logic          k4_wv;
    logic [63:0]   k4_data;
    logic [7:0]    k4_strobe;
    logic [511:0]  k4_bus;
    logic          k4_last;
    logic          k4_busy;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;
    logic bp_en    = 1'b0;
    logic [3:0] bp_pat = 4'b1001;
    int   bp_cnt   = 0;

    always #5 clk = ~clk;

    row_window_splitter #(
        .BIT_WIDTH(BW), .N_COL_FEATURE(F), .N_COL_KERNEL(K), .NUM_STRIDE(S)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .row_valid(row_valid), .row_ready(row_ready),
        .row_data(row_data), .win_valid(win_valid), .win_ready(win_ready),
        .win_data(win_data), .win_strobe(win_strobe), .win_bus(win_bus),
        .win_last(win_last), .busy(busy)
    );

    row_window_splitter #(
        .BIT_WIDTH(BW), .N_COL_FEATURE(8), .N_COL_KERNEL(3), .NUM_STRIDE(3)
    ) u_k3 (
        .clk(clk), .rst_n(rst_n), .row_valid(k3_valid), .row_ready(k3_ready),
        .row_data(k3_row), .win_valid(k3_wv), .win_ready(1'b1),
        .win_data(k3_data), .win_strobe(k3_strobe), .win_bus(k3_bus),
        .win_last(k3_last), .busy(k3_busy)
    );

    row_window_splitter #(
        .BIT_WIDTH(BW), .N_COL_FEATURE(8), .N_COL_KERNEL(4), .NUM_STRIDE(1)
    ) u_k4 (
        .clk(clk), .rst_n(rst_n), .row_valid(k4_valid), .row_ready(k4_ready),
        .row_data(k4_row), .win_valid(k4_wv), .win_ready(1'b1),
        .win_data(k4_data), .win_strobe(k4_strobe), .win_bus(k4_bus),
        .win_last(k4_last), .busy(k4_busy)
    );

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pixel p of a row holds base+p; pixel 0 sits in the MSBs.
    function automatic row_t make_row(input int base);
        row_t r = '0;
        for (int p = 0; p < NPO; p++)
            r[W*(NPO-p)-1 -: W] = W'(base + p);
        return r;
    endfunction

    function automatic win_t exp_win(input int base, input int k);
        win_t w = '0;
        for (int j = 0; j < K; j++)
            w = {w[W*(K-1)-1:0], W'(base + k*S + j)};
        return w;
    endfunction

    task automatic push_row(input int base);
        exp_t e;
        for (int k = 0; k < F; k++) begin
            e.data      = exp_win(base, k);
            e.strobe    = '0;
            e.strobe[k] = 1'b1;
            e.bus       = bus_t'(e.data) << (k*W*K);
            e.last      = (k == F-1);
            sb_q.push_back(e);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the row.
    task automatic send_row(input int base);
        logic accepted = 1'b0;
        push_row(base);
        row_data  = make_row(base);
        row_valid = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (row_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        row_valid = 1'b0;
        check("row_accept", accepted, 1'b1);
    endtask

    task automatic wait_drain(input int limit);
        int i = 0;
        while (sb_q.size() != 0 && i < limit) begin
            @(negedge clk);
            i++;
        end
        check("scoreboard_drained", sb_q.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                win_ready = bp_pat[bp_cnt];
                bp_cnt    = (bp_cnt + 1) % 4;
            end else begin
                win_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on each accepted window and checks holds under backpressure.
    logic         prev_hold = 1'b0;
    logic [729:0] prev_out  = '0;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (!win_valid) begin
                check("idle_strobe", win_strobe, '0);
                check("idle_last", win_last, 1'b0);
            end
            if (prev_hold)
                check("held_outputs", {win_valid, win_data, win_strobe, win_bus, win_last}, prev_out);
            if (win_valid && win_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_window: got strobe %0h, expected no window", win_strobe);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("win_data", win_data, e.data);
                    check("win_strobe", win_strobe, e.strobe);
                    check("win_bus", win_bus, e.bus);
                    check("win_last", win_last, e.last);
                end
            end
            prev_hold = win_valid && !win_ready;
            prev_out  = {win_valid, win_data, win_strobe, win_bus, win_last};
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset behaviour
        rst_n = 1'b0;
        @(negedge clk);
        check("ready_in_reset", row_ready, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", win_valid, 1'b0);
        check("rst_strobe", win_strobe, '0);
        check("rst_data", win_data, '0);
        check("rst_bus", win_bus, '0);
        check("rst_last", win_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", row_ready, 1'b1);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Single row, pixel p = p+1, one window per cycle
        send_row(1);
        @(negedge clk);
        check("latency_valid", win_valid, 1'b1);
        check("w0_hand", win_data, 80'h0001_0002_0003_0004_0005);
        check("w0_strobe", win_strobe, 8'h01);
        @(negedge clk);
        check("w1_hand", win_data, 80'h0003_0004_0005_0006_0007);
        for (int i = 2; i < 8; i++) begin
            @(negedge clk);
            check("consecutive_valid", win_valid, 1'b1);
        end
        check("w7_hand", win_data, 80'h000f_0010_0011_0012_0013);
        check("w7_last", win_last, 1'b1);
        @(negedge clk);
        check("row_done_valid", win_valid, 1'b0);
        check("row_done_busy", busy, 1'b0);
        wait_drain(10);
        @(posedge clk);
        #1;

        // Alternate geometries, pixel p = p+1
        for (int p = 0; p < 24; p++) k3_row[16*(24-p)-1 -: 16] = 16'(p + 1);
        for (int p = 0; p < 11; p++) k4_row[16*(11-p)-1 -: 16] = 16'(p + 1);
        k3_valid = 1'b1;
        k4_valid = 1'b1;
        @(negedge clk);
        check("k3_ready", k3_ready, 1'b1);
        check("k4_ready", k4_ready, 1'b1);
        @(posedge clk);
        #1;
        k3_valid = 1'b0;
        k4_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [47:0] w3;
            logic [63:0] w4;
            logic [7:0]  sb;
            w3 = '0;
            w4 = '0;
            sb = '0;
            sb[k] = 1'b1;
            for (int j = 0; j < 3; j++) w3 = {w3[31:0], 16'(k*3 + j + 1)};
            for (int j = 0; j < 4; j++) w4 = {w4[47:0], 16'(k + j + 1)};
            @(negedge clk);
            check("k3_valid", k3_wv, 1'b1);
            check("k3_data", k3_data, w3);
            check("k3_strobe", k3_strobe, sb);
            check("k3_bus", k3_bus, 384'(k3_data) << (k*48));
            check("k3_last", k3_last, k == 7);
            check("k4_data", k4_data, w4);
            check("k4_strobe", k4_strobe, sb);
            check("k4_bus", k4_bus, 512'(k4_data) << (k*64));
            check("k4_last", k4_last, k == 7);
            if (k == 2) check("k3_w2_hand", k3_data, 48'h0007_0008_0009);
            if (k == 7) check("k4_w7_hand", k4_data, 64'h0008_0009_000a_000b);
        end
        @(negedge clk);
        check("k3_done_busy", k3_busy, 1'b0);
        check("k4_done_busy", k4_busy, 1'b0);
        @(posedge clk);
        #1;

        // Back-to-back rows: second row into pending, 16 windows in 16 cycles
        send_row(16'h21);
        send_row(16'h41);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("b2b_valid", win_valid, 1'b1);
            check("b2b_row_ready", row_ready, i >= 7);
        end
        @(negedge clk);
        check("b2b_end_valid", win_valid, 1'b0);
        wait_drain(10);
        @(posedge clk);
        #1;

        // Backpressure 1,0,0,1,... with a second row loaded into pending while stalled
        bp_en = 1'b1;
        send_row(16'h61);
        send_row(16'ha1);
        wait_drain(200);
        bp_en = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_end_busy", busy, 1'b0);
        @(posedge clk);
        #1;

        // Last window accepted with empty pending while a row is offered
        send_row(16'h71);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
        end
        check("direct_pre_last", win_last, 1'b1);
        send_row(16'h81);
        @(negedge clk);
        check("direct_valid", win_valid, 1'b1);
        check("direct_strobe", win_strobe, 8'h01);
        check("direct_hand", win_data, 80'h0081_0082_0083_0084_0085);
        wait_drain(20);
        @(posedge clk);
        #1;

        // Reset mid-row at idx=3 with pending full
        send_row(16'h301);
        send_row(16'h401);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_reset_strobe", win_strobe, 8'h08);
        check("pre_reset_ready", row_ready, 1'b0);
        rst_n = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        check("mid_rst_valid", win_valid, 1'b0);
        check("mid_rst_strobe", win_strobe, '0);
        check("mid_rst_data", win_data, '0);
        check("mid_rst_bus", win_bus, '0);
        check("mid_rst_last", win_last, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", row_ready, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", row_ready, 1'b1);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_valid", win_valid, 1'b0);
        @(posedge clk);
        #1;
        send_row(16'h501);
        @(negedge clk);
        check("post_rst_w0_strobe", win_strobe, 8'h01);
        check("post_rst_w0_hand", win_data, 80'h0501_0502_0503_0504_0505);
        wait_drain(20);
        @(negedge clk);
        check("final_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
